// File: rtl/ddr3_pkg.sv
// Shared command encodings and scheduler types for the DDR3 read/write scheduler.
package ddr3_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {IDLE, WR, RD} sched_state_t;

  typedef enum logic {DIR_WR, DIR_RD} dir_t;

endpackage

// File: rtl/ddr3_credit_counter.sv
// Outstanding-read counter: +1 per accepted read, -1 per returned beat,
// with a sticky flag for a return that arrives when nothing is outstanding.
module ddr3_credit_counter #(
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 inc,
  input  logic                                 dec,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] count,
  output logic                                 credit_err
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      credit_err <= 1'b0;
    end else if (inc && !dec) begin
      count <= count + CW'(1);
    end else if (dec && !inc) begin
      if (count == '0) credit_err <= 1'b1;
      else             count      <= count - CW'(1);
    end
  end

endmodule

// File: rtl/ddr3_rw_scheduler.sv
// Alternating write/read burst scheduler feeding the DDR3 controller command port.
// Optional read-after-write protection: define DDR3_SCHED_RAW_CHECK_EN.
module ddr3_rw_scheduler
  import ddr3_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH      = 128,
  parameter int unsigned WR_BURST_MAX    = 8,
  parameter int unsigned RD_BURST_MAX    = 8,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     EN,
  input  logic                     write_fifo_empty,
  input  logic [ADDRESS_WIDTH-1:0] write_fifo_address,
  input  logic [DATA_WIDTH-1:0]    write_fifo_data,
  output logic                     write_fifo_read,
  input  logic                     read_in_fifo_empty,
  input  logic [ADDRESS_WIDTH-1:0] read_in_fifo_address,
  output logic                     read_in_fifo_read,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [2:0]               cmd_op,
  output logic [28:0]              cmd_addr,
  output logic [DATA_WIDTH-1:0]    cmd_wdata,
  input  logic                     rd_return,
  output logic                     busy,
  output logic                     credit_err
);

  localparam int unsigned BURST_MAX = (WR_BURST_MAX > RD_BURST_MAX) ? WR_BURST_MAX : RD_BURST_MAX;
  localparam int unsigned BW = $clog2(BURST_MAX + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  sched_state_t  state;
  dir_t          last_dir;
  logic [BW-1:0] burst_cnt;
  logic [OW-1:0] outstanding;
  logic [OW:0]   inflight;
  logic          we, re, hazard, pending_rd, load, wr_done, rd_done, rd_accept;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^{write_fifo_address[ADDRESS_WIDTH-1:29],
                            read_in_fifo_address[ADDRESS_WIDTH-1:29]};

`ifdef DDR3_SCHED_RAW_CHECK_EN
  assign hazard = !write_fifo_empty &&
                  (read_in_fifo_address[28:0] == write_fifo_address[28:0]);
`else
  assign hazard = 1'b0;
`endif

  // A read sitting in the command register is not yet counted as outstanding.
  assign pending_rd = cmd_valid && (cmd_op == CMD_READ);
  assign inflight   = {1'b0, outstanding} + {{OW{1'b0}}, pending_rd};
  assign we         = !write_fifo_empty;
  assign re         = !read_in_fifo_empty && (inflight < (OW+1)'(MAX_OUTSTANDING)) && !hazard;
  assign load       = !cmd_valid || cmd_ready;

  // The cycle that ends a burst loads nothing; that is the switch bubble.
  assign wr_done = (burst_cnt == BW'(WR_BURST_MAX)) || !we;
  assign rd_done = (burst_cnt == BW'(RD_BURST_MAX)) || !re;

  assign write_fifo_read   = EN && (state == WR) && !wr_done && load;
  assign read_in_fifo_read = EN && (state == RD) && !rd_done && load;
  assign rd_accept         = cmd_valid && cmd_ready && (cmd_op == CMD_READ);
  assign busy              = (state != IDLE) || cmd_valid || (outstanding != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_dir  <= DIR_RD;
      burst_cnt <= '0;
    end else if (!EN) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if ((we && re && last_dir == DIR_RD) || (we && !re)) begin
            state    <= WR;
            last_dir <= DIR_WR;
          end else if (re) begin
            state    <= RD;
            last_dir <= DIR_RD;
          end
        end
        WR: begin
          if (wr_done) begin
            burst_cnt <= '0;
            if (re) begin
              state    <= RD;
              last_dir <= DIR_RD;
            end else if (!we) begin
              state <= IDLE;
            end
          end else if (load) begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
        RD: begin
          if (rd_done) begin
            burst_cnt <= '0;
            if (we) begin
              state    <= WR;
              last_dir <= DIR_WR;
            end else if (!re) begin
              state <= IDLE;
            end
          end else if (load) begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_op    <= CMD_WRITE;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (write_fifo_read) begin
      cmd_valid <= 1'b1;
      cmd_op    <= CMD_WRITE;
      cmd_addr  <= write_fifo_address[28:0];
      cmd_wdata <= write_fifo_data;
    end else if (read_in_fifo_read) begin
      cmd_valid <= 1'b1;
      cmd_op    <= CMD_READ;
      cmd_addr  <= read_in_fifo_address[28:0];
      cmd_wdata <= '0;
    end else if (cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

  ddr3_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (rd_accept),
    .dec       (rd_return),
    .count     (outstanding),
    .credit_err(credit_err)
  );

endmodule

// File: tb/tb_ddr3_rw_scheduler.sv
// Scoreboard bench for ddr3_rw_scheduler: directed FIFO contents, expected commands queued in issue order.
module tb_ddr3_rw_scheduler;
  import ddr3_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         EN = 1'b0;
  logic         write_fifo_empty, read_in_fifo_empty;
  logic [31:0]  write_fifo_address, read_in_fifo_address;
  logic [127:0] write_fifo_data;
  logic         write_fifo_read, read_in_fifo_read;
  logic         cmd_valid;
  logic         cmd_ready = 1'b0;
  logic [2:0]   cmd_op;
  logic [28:0]  cmd_addr;
  logic [127:0] cmd_wdata;
  logic         rd_return;
  logic         busy, credit_err;

  always #5 clk = ~clk;

  ddr3_rw_scheduler #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(128), .WR_BURST_MAX(8), .RD_BURST_MAX(8), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .EN(EN),
    .write_fifo_empty(write_fifo_empty), .write_fifo_address(write_fifo_address),
    .write_fifo_data(write_fifo_data), .write_fifo_read(write_fifo_read),
    .read_in_fifo_empty(read_in_fifo_empty), .read_in_fifo_address(read_in_fifo_address),
    .read_in_fifo_read(read_in_fifo_read),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rd_return(rd_return), .busy(busy), .credit_err(credit_err)
  );

  // FWFT FIFO models
  logic [31:0]  wq_addr [0:63];
  logic [127:0] wq_data [0:63];
  logic [31:0]  rq_addr [0:63];
  int wr_cnt = 0, rd_cnt = 0, wr_ptr, rd_ptr;

  assign write_fifo_empty     = (wr_ptr >= wr_cnt);
  assign read_in_fifo_empty   = (rd_ptr >= rd_cnt);
  assign write_fifo_address   = wq_addr[wr_ptr];
  assign write_fifo_data      = wq_data[wr_ptr];
  assign read_in_fifo_address = rq_addr[rd_ptr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 0;
      rd_ptr <= 0;
    end else begin
      if (write_fifo_read) wr_ptr <= wr_ptr + 1;
      if (read_in_fifo_read) rd_ptr <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [2:0]   op;
    logic [28:0]  addr;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc[$];
  int   acc_n = 0, cyc = 0, tests = 0, fails = 0;
  int   ret_pending = 0, ret_grant = 0;
  bit   auto_ret = 1'b0, force_ret = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] wd(input logic [31:0] a);
    return {a, ~a, a ^ 32'hDEADBEEF, a + 32'h1};
  endfunction

  task automatic exp_push(input logic [2:0] op, input logic [31:0] a, input logic [127:0] d);
    exp_t e;
    e.op = op; e.addr = a[28:0]; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input bit expect_it);
    wq_addr[wr_cnt] = a; wq_data[wr_cnt] = wd(a); wr_cnt++;
    if (expect_it) exp_push(CMD_WRITE, a, wd(a));
  endtask

  task automatic push_rd(input logic [31:0] a, input bit expect_it);
    rq_addr[rd_cnt] = a; rd_cnt++;
    if (expect_it) exp_push(CMD_READ, a, '0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_acc(input int target, input string name);
    int n;
    n = 0;
    while (acc_n < target && n < 200) begin tick(); n++; end
    chk(name, 128'(acc_n >= target), 128'(1));
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin tick(); n++; end
    chk(name, 128'(exp_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_cnt = 0; rd_cnt = 0;
    ret_pending = 0; ret_grant = 0; auto_ret = 1'b0; force_ret = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every accepted command is popped against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n && cmd_valid && cmd_ready) begin
      acc_cyc.push_back(cyc);
      acc_n++;
      if (cmd_op == CMD_READ) ret_pending++;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected: got op %0d addr %0h, required no command", cmd_op, cmd_addr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_op", 128'(cmd_op), 128'(e.op));
        chk("sb_addr", 128'(cmd_addr), 128'(e.addr));
        chk("sb_wdata", cmd_wdata, e.data);
      end
    end
  end

  // Read-return driver.
  initial begin
    rd_return = 1'b0;
    forever begin
      tick();
      if (force_ret) begin
        rd_return = 1'b1; force_ret = 1'b0;
      end else if (ret_pending > 0 && (auto_ret || ret_grant > 0)) begin
        rd_return = 1'b1; ret_pending--;
        if (ret_grant > 0) ret_grant--;
      end else begin
        rd_return = 1'b0;
      end
    end
  end

  initial begin
    int base;
    bit bnd [0:39];

    // Reset with three writes queued
    EN = 1'b1; cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_wr(32'hE000_0040 + 32'(i) * 32'h10, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_cmd_valid", 128'(cmd_valid), 128'(0));
    chk("rst_cmd_op", 128'(cmd_op), 128'(0));
    chk("rst_cmd_addr", 128'(cmd_addr), 128'(0));
    chk("rst_cmd_wdata", cmd_wdata, '0);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_credit_err", 128'(credit_err), 128'(0));
    chk("rst_pops", 128'({write_fifo_read, read_in_fifo_read}), 128'(0));
    tick();
    rst_n = 1'b1;
    base = acc_n;
    @(negedge clk); chk("t1_c_valid", 128'(cmd_valid), 128'(0));
    @(negedge clk); chk("t1_c1_valid", 128'(cmd_valid), 128'(0));
    chk("t1_c1_pop", 128'(write_fifo_read), 128'(1));
    @(negedge clk); chk("t1_c2_valid", 128'(cmd_valid), 128'(1));
    @(negedge clk); @(negedge clk); chk("t1_c4_busy", 128'(busy), 128'(1));
    @(negedge clk); chk("t1_c5_valid", 128'(cmd_valid), 128'(0));
    chk("t1_c5_busy", 128'(busy), 128'(0));
    wait_drain("t1_drain");
    chk("t1_count", 128'(acc_n - base), 128'(3));
    chk("t1_gap1", 128'(acc_cyc[base+1] - acc_cyc[base]), 128'(1));
    chk("t1_gap2", 128'(acc_cyc[base+2] - acc_cyc[base+1]), 128'(1));

    // 20 writes + 20 reads: W8 R8 W8 R8 W4 R4
    do_reset();
    auto_ret = 1'b1;
    for (int i = 0; i < 20; i++) push_wr(32'h1000_0000 + 32'(i) * 32'h40, 1'b0);
    for (int i = 0; i < 20; i++) push_rd(32'h2000_0000 + 32'(i) * 32'h40, 1'b0);
    for (int k = 0; k < 40; k++) bnd[k] = (k == 8 || k == 16 || k == 24 || k == 32 || k == 36);
    for (int b = 0; b < 3; b++) begin
      int len;
      len = (b == 2) ? 4 : 8;
      for (int i = 0; i < len; i++) exp_push(CMD_WRITE, 32'h1000_0000 + 32'(b * 8 + i) * 32'h40,
                                             wd(32'h1000_0000 + 32'(b * 8 + i) * 32'h40));
      for (int i = 0; i < len; i++) exp_push(CMD_READ, 32'h2000_0000 + 32'(b * 8 + i) * 32'h40, '0);
    end
    base = acc_n;
    wait_drain("t2_drain");
    for (int k = 1; k < 40; k++)
      chk($sformatf("t2_gap%0d", k), 128'(acc_cyc[base+k] - acc_cyc[base+k-1]), bnd[k] ? 128'(2) : 128'(1));

    // Credit cap of 4 with returns withheld
    do_reset();
    for (int i = 0; i < 10; i++) push_rd(32'h0300_0000 + 32'(i) * 32'h8, 1'b1);
    base = acc_n;
    repeat (30) tick();
    chk("t3_cap", 128'(acc_n - base), 128'(4));
    chk("t3_busy", 128'(busy), 128'(1));
    ret_grant = 1;
    repeat (30) tick();
    chk("t3_one_more", 128'(acc_n - base), 128'(5));
    auto_ret = 1'b1;
    wait_drain("t3_drain");
    repeat (10) tick();

    // cmd_ready low 5 cycles mid-burst
    do_reset();
    for (int i = 0; i < 6; i++) push_wr(32'h0000_4000 + 32'(i) * 32'h10, 1'b1);
    base = acc_n;
    wait_acc(base + 2, "t4_wait2");
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 128'(cmd_valid), 128'(1));
      chk("t4_hold_addr", 128'(cmd_addr), 128'(29'h0000_4020));
      chk("t4_hold_wdata", cmd_wdata, wd(32'h0000_4020));
      chk("t4_no_pop", 128'(write_fifo_read), 128'(0));
    end
    tick();
    cmd_ready = 1'b1;
    wait_drain("t4_drain");
    for (int k = 3; k < 6; k++)
      chk("t4_resume_gap", 128'(acc_cyc[base+k] - acc_cyc[base+k-1]), 128'(1));

    // Read-after-write ordering on same address
    do_reset();
    auto_ret = 1'b1;
    push_rd(32'h0000_0200, 1'b0);
    push_rd(32'hE000_0100, 1'b0);
    tick();
    push_wr(32'h0000_0100, 1'b0);
    exp_push(CMD_READ, 32'h0000_0200, '0);
`ifdef DDR3_SCHED_RAW_CHECK_EN
    exp_push(CMD_WRITE, 32'h0000_0100, wd(32'h0000_0100));
    exp_push(CMD_READ, 32'hE000_0100, '0);
`else
    exp_push(CMD_READ, 32'hE000_0100, '0);
    exp_push(CMD_WRITE, 32'h0000_0100, wd(32'h0000_0100));
`endif
    wait_drain("t5_drain");
    repeat (10) tick();

    // Underflow return, then EN dropped with a command pending
    do_reset();
    chk("t6_err_clear", 128'(credit_err), 128'(0));
    force_ret = 1'b1;
    repeat (3) tick();
    chk("t6_err_set", 128'(credit_err), 128'(1));
    repeat (5) tick();
    chk("t6_err_sticky", 128'(credit_err), 128'(1));
    for (int i = 0; i < 6; i++) push_wr(32'h0000_8000 + 32'(i) * 32'h10, 1'b1);
    base = acc_n;
    wait_acc(base + 2, "t6_wait2");
    cmd_ready = 1'b0; EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_hold_valid", 128'(cmd_valid), 128'(1));
      chk("t6_hold_addr", 128'(cmd_addr), 128'(29'h0000_8020));
      chk("t6_no_pop", 128'(write_fifo_read), 128'(0));
    end
    tick();
    cmd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_off_valid", 128'(cmd_valid), 128'(i == 0));
      chk("t6_off_pop", 128'(write_fifo_read), 128'(0));
    end
    chk("t6_off_busy", 128'(busy), 128'(0));
    chk("t6_off_count", 128'(acc_n - base), 128'(3));
    tick();
    EN = 1'b1;
    wait_drain("t6_drain");
    chk("t6_total", 128'(acc_n - base), 128'(6));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
